// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared types and defaults for the ROB retirement engine.
//   rob_entry_t    : one reorder-buffer entry as seen at the extract end
//   commit_state_t : retirement FSM states
//   ROB_DEPTH / ROB_EXT_COUNT : default ROB depth and head-window width
package rob_commit_pkg;

  localparam int ROB_DEPTH     = 16;
  localparam int ROB_EXT_COUNT = 4;

  typedef struct packed {
    logic        dest_reg_valid;
    logic [4:0]  dest_reg;
    logic [31:0] result_lo;
    logic        branch_mispredict;
    logic [31:0] target_pc;
  } rob_entry_t;

  typedef enum logic [0:0] {
    CS_RUN      = 1'b0,
    CS_REDIRECT = 1'b1
  } commit_state_t;

endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: combinational scan of the ROB head window.
// Finds the contiguous run of completed, occupied slots and the first
// mispredicted branch in it, then decides how many entries may retire.
// Ports:
//   slot_data, slot_valid, rob_used_count : head window and occupancy
//   retire_cnt  : entries to retire (0..EXT_COUNT)
//   retire_mask : one bit per retiring slot, slot 0 = oldest
//   flush_req   : branch plus delay slot retire, younger entries flush
//   mp_idx      : slot of the first eligible mispredicted branch
//   mp_target   : that branch's target_pc
module rob_commit_select
  import rob_commit_pkg::*;
#(
  parameter type T            = rob_entry_t,
  parameter int  EXT_COUNT    = ROB_EXT_COUNT,
  parameter int  DEPTHLOG2    = 4,
  parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  T     [EXT_COUNT-1:0]    slot_data,
  input  logic [EXT_COUNT-1:0]    slot_valid,
  input  logic [DEPTHLOG2:0]      rob_used_count,
  output logic [EXTCOUNTLOG2:0]   retire_cnt,
  output logic [EXT_COUNT-1:0]    retire_mask,
  output logic                    flush_req,
  output logic [EXTCOUNTLOG2-1:0] mp_idx,
  output logic [31:0]             mp_target
);

  localparam int UW = DEPTHLOG2 + 1;
  localparam int CW = EXTCOUNTLOG2 + 1;
  localparam int EW = EXTCOUNTLOG2;

  logic                 run;
  logic                 has_mp;
  logic [EXT_COUNT-1:0] elig;
  logic [EXT_COUNT:0]   elig_ext;
  logic [CW-1:0]        n;

  always_comb begin
    run  = 1'b1;
    elig = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      run     = run && slot_valid[i] && (rob_used_count > UW'(i));
      elig[i] = run;
    end
    // Extra zero bit lets the last slot look at a nonexistent delay slot.
    elig_ext = {1'b0, elig};

    n = '0;
    for (int i = 0; i < EXT_COUNT; i++)
      if (elig[i]) n = n + CW'(1);

    has_mp     = 1'b0;
    mp_idx     = '0;
    mp_target  = '0;
    flush_req  = 1'b0;
    retire_cnt = n;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!has_mp && elig[i] && slot_data[i].branch_mispredict) begin
        has_mp     = 1'b1;
        mp_idx     = EW'(i);
        mp_target  = slot_data[i].target_pc;
        flush_req  = elig_ext[i+1];
        // Branch retires only together with its delay slot.
        retire_cnt = flush_req ? CW'(i + 2) : CW'(i);
      end
    end

    retire_mask = '0;
    for (int i = 0; i < EXT_COUNT; i++)
      retire_mask[i] = (CW'(i) < retire_cnt);
  end

endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement engine at the ROB extract end.
// Retires up to EXT_COUNT completed head entries per cycle, writes the
// register file one cycle later, and on a mispredicted branch retires the
// branch plus delay slot, flushes younger entries and pulses a redirect.
// Ports:
//   clock, reset_n (async, active-low)
//   slot_data/slot_valid/rob_used_count/commit_hold : ROB head view, stall
//   consume/consume_count/flush/flush_idx           : ROB handshake (comb)
//   rf_wr_en/rf_wr_addr/rf_wr_data                  : regfile ports (registered)
//   redirect_valid/redirect_pc                      : fetch redirect
// Optional: ROB_COMMIT_PERF_EN adds perf_retired and perf_stall counters.
// DEPTH is assumed a power of two so head/flush indices wrap naturally.
//
// state       | meaning
// CS_RUN      | retiring normally
// CS_REDIRECT | one-cycle redirect pulse after a mispredict flush
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter type T            = rob_entry_t,
  parameter int  DEPTH        = ROB_DEPTH,
  parameter int  EXT_COUNT    = ROB_EXT_COUNT,
  parameter int  DEPTHLOG2    = $clog2(DEPTH),
  parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  T     [EXT_COUNT-1:0]          slot_data,
  input  logic [EXT_COUNT-1:0]          slot_valid,
  input  logic [DEPTHLOG2:0]            rob_used_count,
  input  logic                          commit_hold,
  output logic                          consume,
  output logic [EXTCOUNTLOG2-1:0]       consume_count,
  output logic                          flush,
  output logic [DEPTHLOG2-1:0]          flush_idx,
  output logic [EXT_COUNT-1:0]          rf_wr_en,
  output logic [EXT_COUNT-1:0][4:0]     rf_wr_addr,
  output logic [EXT_COUNT-1:0][31:0]    rf_wr_data,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_pc
`ifdef ROB_COMMIT_PERF_EN
  ,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_stall
`endif
);

  commit_state_t             state;
  logic [DEPTHLOG2-1:0]      head_idx;
  logic [EXTCOUNTLOG2:0]     retire_cnt;
  logic [EXT_COUNT-1:0]      retire_mask;
  logic                      flush_req;
  logic [EXTCOUNTLOG2-1:0]   mp_idx;
  logic [31:0]               mp_target;
  logic                      active;
  logic [EXT_COUNT-1:0]      wr_next;

  rob_commit_select #(
    .T            (T),
    .EXT_COUNT    (EXT_COUNT),
    .DEPTHLOG2    (DEPTHLOG2),
    .EXTCOUNTLOG2 (EXTCOUNTLOG2)
  ) u_select (
    .slot_data      (slot_data),
    .slot_valid     (slot_valid),
    .rob_used_count (rob_used_count),
    .retire_cnt     (retire_cnt),
    .retire_mask    (retire_mask),
    .flush_req      (flush_req),
    .mp_idx         (mp_idx),
    .mp_target      (mp_target)
  );

  // reset_n gates the handshake so the ROB sees nothing during reset.
  assign active        = reset_n && (state == CS_RUN) && !commit_hold;
  assign consume       = active && (retire_cnt != '0);
  assign consume_count = EXTCOUNTLOG2'(retire_cnt - 1'b1);
  assign flush         = active && flush_req;
  assign flush_idx     = head_idx + DEPTHLOG2'(mp_idx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= CS_RUN;
      head_idx       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (consume)
        head_idx <= head_idx + DEPTHLOG2'(retire_cnt);
      case (state)
        CS_RUN: begin
          if (flush) begin
            state          <= CS_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= mp_target;
          end
        end
        CS_REDIRECT: begin
          state          <= CS_RUN;
          redirect_valid <= 1'b0;
        end
        default: begin
          state          <= CS_RUN;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // WAW suppression: only the youngest retiring writer of a register writes.
  always_comb begin
    wr_next = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      wr_next[i] = consume && retire_mask[i] && slot_data[i].dest_reg_valid &&
                   (slot_data[i].dest_reg != 5'd0);
      for (int j = i + 1; j < EXT_COUNT; j++)
        if (retire_mask[j] && slot_data[j].dest_reg_valid &&
            (slot_data[j].dest_reg == slot_data[i].dest_reg))
          wr_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en   <= '0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= wr_next;
      for (int i = 0; i < EXT_COUNT; i++) begin
        rf_wr_addr[i] <= slot_data[i].dest_reg;
        rf_wr_data[i] <= slot_data[i].result_lo;
      end
    end
  end

`ifdef ROB_COMMIT_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (consume)
        perf_retired <= perf_retired + 32'(retire_cnt);
      if ((rob_used_count != '0) && !consume)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed-vector bench for rob_commit with hand-computed
// expectations for retirement width, mispredict flush/redirect, regfile
// WAW suppression, hold and reset behaviour.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic                 clock;
  logic                 reset_n;
  rob_entry_t [3:0]     slot_data;
  logic [3:0]           slot_valid;
  logic [4:0]           rob_used_count;
  logic                 commit_hold;
  logic                 consume;
  logic [1:0]           consume_count;
  logic                 flush;
  logic [3:0]           flush_idx;
  logic [3:0]           rf_wr_en;
  logic [3:0][4:0]      rf_wr_addr;
  logic [3:0][31:0]     rf_wr_data;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
`ifdef ROB_COMMIT_PERF_EN
  logic [31:0]          perf_retired;
  logic [31:0]          perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  rob_commit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .slot_data      (slot_data),
    .slot_valid     (slot_valid),
    .rob_used_count (rob_used_count),
    .commit_hold    (commit_hold),
    .consume        (consume),
    .consume_count  (consume_count),
    .flush          (flush),
    .flush_idx      (flush_idx),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_addr     (rf_wr_addr),
    .rf_wr_data     (rf_wr_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef ROB_COMMIT_PERF_EN
    ,
    .perf_retired   (perf_retired),
    .perf_stall     (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int i, input logic dv, input logic [4:0] d,
                          input logic [31:0] r, input logic mp, input logic [31:0] tgt);
    slot_data[i].dest_reg_valid    = dv;
    slot_data[i].dest_reg          = d;
    slot_data[i].result_lo         = r;
    slot_data[i].branch_mispredict = mp;
    slot_data[i].target_pc         = tgt;
  endtask

  // Plain entries: slot i writes r(i+1) with result base+i, no mispredict.
  task automatic plain(input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      set_slot(i, 1'b1, 5'(i + 1), base + 32'(i), 1'b0, 32'h0);
  endtask

  initial begin
    reset_n        = 1'b0;
    commit_hold    = 1'b0;
    plain(32'h100);
    slot_valid     = 4'b1111;
    rob_used_count = 5'd4;
    #3;
    chk("rst_consume", 32'(consume), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_head_idx", 32'(dut.head_idx), 32'd0);
    tick;
    tick;
    reset_n = 1'b1;
    #1;

    // 1: four completed entries retire together
    chk("t1_consume", 32'(consume), 32'd1);
    chk("t1_count", 32'(consume_count), 32'd3);
    chk("t1_flush", 32'(flush), 32'd0);
    tick;
    chk("t1_rf_wr_en", 32'(rf_wr_en), 32'hf);
    chk("t1_rf_addr2", 32'(rf_wr_addr[2]), 32'd3);
    chk("t1_rf_data3", rf_wr_data[3], 32'h103);
    chk("t1_head", 32'(dut.head_idx), 32'd4);

    // 2: partial completion, hole at slot 0, occupancy limit
    slot_valid = 4'b1011;
    #1;
    chk("t2a_consume", 32'(consume), 32'd1);
    chk("t2a_count", 32'(consume_count), 32'd1);
    tick;
    chk("t2a_head", 32'(dut.head_idx), 32'd6);
    slot_valid = 4'b1110;
    #1;
    chk("t2b_consume", 32'(consume), 32'd0);
    tick;
    chk("t2b_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("t2b_head", 32'(dut.head_idx), 32'd6);
    slot_valid     = 4'b1111;
    rob_used_count = 5'd2;
    #1;
    chk("t2c_consume", 32'(consume), 32'd1);
    chk("t2c_count", 32'(consume_count), 32'd1);
    tick;
    chk("t2c_head", 32'(dut.head_idx), 32'd8);
    rob_used_count = 5'd0;
    #1;
    chk("t2d_used0_consume", 32'(consume), 32'd0);
    tick;
    rob_used_count = 5'd4;
    tick;
    chk("t2e_head", 32'(dut.head_idx), 32'd12);
    rob_used_count = 5'd2;
    tick;
    chk("t2f_head", 32'(dut.head_idx), 32'd14);

    // 3: mispredict at slot 1 with delay slot done, head wraps
    rob_used_count = 5'd4;
    plain(32'h200);
    set_slot(1, 1'b1, 5'd2, 32'h201, 1'b1, 32'h8000_0040);
    #1;
    chk("t3_consume", 32'(consume), 32'd1);
    chk("t3_count", 32'(consume_count), 32'd2);
    chk("t3_flush", 32'(flush), 32'd1);
    chk("t3_flush_idx", 32'(flush_idx), 32'd15);
    tick;
    chk("t3_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("t3_redirect_pc", redirect_pc, 32'h8000_0040);
    chk("t3_redir_consume", 32'(consume), 32'd0);
    chk("t3_redir_flush", 32'(flush), 32'd0);
    chk("t3_head", 32'(dut.head_idx), 32'd1);
    chk("t3_rf_wr_en", 32'(rf_wr_en), 32'h7);
    slot_valid = 4'b0000;
    tick;
    chk("t3_pulse_end", 32'(redirect_valid), 32'd0);
    chk("t3_head_hold", 32'(dut.head_idx), 32'd1);

    // 4: mispredict in last slot, and at slot 0 without delay slot
    plain(32'h300);
    set_slot(3, 1'b1, 5'd4, 32'h303, 1'b1, 32'h9000_0000);
    slot_valid = 4'b1111;
    #1;
    chk("t4a_consume", 32'(consume), 32'd1);
    chk("t4a_count", 32'(consume_count), 32'd2);
    chk("t4a_flush", 32'(flush), 32'd0);
    tick;
    chk("t4a_head", 32'(dut.head_idx), 32'd4);
    chk("t4a_no_redirect", 32'(redirect_valid), 32'd0);
    plain(32'h400);
    set_slot(0, 1'b1, 5'd1, 32'h400, 1'b1, 32'h9000_0100);
    slot_valid = 4'b1101;
    #1;
    chk("t4b_consume", 32'(consume), 32'd0);
    chk("t4b_flush", 32'(flush), 32'd0);
    tick;
    chk("t4b_head", 32'(dut.head_idx), 32'd4);

    // 5: WAW on r5 and write to r0
    set_slot(0, 1'b1, 5'd5, 32'haaaa, 1'b0, 32'h0);
    set_slot(1, 1'b1, 5'd0, 32'hbbbb, 1'b0, 32'h0);
    set_slot(2, 1'b1, 5'd5, 32'hcccc, 1'b0, 32'h0);
    set_slot(3, 1'b0, 5'd7, 32'hdddd, 1'b0, 32'h0);
    slot_valid = 4'b1111;
    #1;
    chk("t5_count", 32'(consume_count), 32'd3);
    tick;
    chk("t5_rf_wr_en", 32'(rf_wr_en), 32'h4);
    chk("t5_rf_addr2", 32'(rf_wr_addr[2]), 32'd5);
    chk("t5_rf_data2", rf_wr_data[2], 32'hcccc);
    chk("t5_head", 32'(dut.head_idx), 32'd8);

    // 6: hold defers a pending mispredict, then reset during redirect
    plain(32'h600);
    set_slot(1, 1'b1, 5'd2, 32'h601, 1'b1, 32'h7000_0010);
    commit_hold = 1'b1;
    #1;
    chk("t6_hold_consume", 32'(consume), 32'd0);
    chk("t6_hold_flush", 32'(flush), 32'd0);
    tick;
    chk("t6_hold_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("t6_hold_redirect", 32'(redirect_valid), 32'd0);
    chk("t6_hold_head", 32'(dut.head_idx), 32'd8);
    commit_hold = 1'b0;
    #1;
    chk("t6_flush", 32'(flush), 32'd1);
    chk("t6_flush_idx", 32'(flush_idx), 32'd9);
    tick;
    chk("t6_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("t6_redirect_pc", redirect_pc, 32'h7000_0010);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("t6_rst_redirect_pc", redirect_pc, 32'd0);
    chk("t6_rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("t6_rst_consume", 32'(consume), 32'd0);
    chk("t6_rst_flush", 32'(flush), 32'd0);
    chk("t6_rst_head", 32'(dut.head_idx), 32'd0);
    tick;
    plain(32'h700);
    slot_valid     = 4'b0001;
    rob_used_count = 5'd1;
    reset_n        = 1'b1;
    #1;
    chk("t6_post_consume", 32'(consume), 32'd1);
    chk("t6_post_count", 32'(consume_count), 32'd0);
    tick;
    chk("t6_post_redirect", 32'(redirect_valid), 32'd0);
    chk("t6_post_head", 32'(dut.head_idx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
